aes_key_expand_seq: RTL
=======================

Name: aes_key_expand_seq

Overview:
Sequential AES key-schedule generator that sits directly upstream of the pipelined AES encrypt datapath. It accepts a cipher key and produces one 32-bit schedule word per clock, using a single shared SubWord unit. It presents the full packed round-key bus plus a level `key_ready` flag, in the exact format the encrypt pipeline consumes. It replaces a combinational schedule to cut S-box area (4 S-boxes total).

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- Nr, 10, round count; must equal Nk+6 (10/12/14).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- key_in  input  Nk*32  cipher key. Word w[0] is at the MSBs.
- key_load  input  1  single-cycle start pulse; key_in is sampled on the same edge.
- keys_out  output  (Nr+1)*128  packed schedule. Word w[i] sits at bits [(4*(Nr+1)-i)*32-1 -: 32]. Round 0 key is at the MSBs; round Nr key is at [127:0].
- key_ready  output  1  level flag; high when all 4*(Nr+1) words are valid.
- busy  output  1  high while in EXPAND.

Behaviour:
- Reset (asynchronous):
  - keys_out = 0, key_ready = 0, busy = 0.
  - FSM goes to IDLE.
  - Word index register = 0, rcon = 8'h01.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE: on key_load -> EXPAND.
  - EXPAND: advances one word per cycle. After writing word 4*(Nr+1)-1 -> DONE.
  - DONE: holds. On key_load -> EXPAND.
- Load edge (any state, key_load=1):
  - w[0..Nk-1] <= key_in.
  - All other words cleared to 0.
  - i <= Nk, rcon <= 8'h01, key_ready <= 0, busy <= 1.
  - key_load during EXPAND aborts the current expansion and restarts it; no partial result survives.
- Each EXPAND cycle computes and writes word i, then increments i:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon <= xtime(rcon). xtime is the left shift with conditional ^8'h1b, giving the sequence 01,02,04,08,10,20,40,80,1b,36.
  - Else if Nk == 8 and i mod Nk == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - i mod Nk is tracked with a wrap counter (0..Nk-1). No divider is used.
- Last word:
  - Word 4*(Nr+1)-1 is written on the same edge that sets key_ready = 1 and busy = 0.
  - key_ready is therefore never high while any word is stale.
- Latency from the key_load edge to key_ready high = 4*(Nr+1)-Nk cycles:
  - Nk=4: 40 cycles.
  - Nk=6: 46 cycles.
  - Nk=8: 52 cycles.
- key_ready stays high until reset or the next key_load. It is never pulsed.
- key_in changes while key_load=0 have no effect.
- keys_out words update only on their own write edge; earlier words stay stable during expansion.
- Reset asserted mid-EXPAND: all state clears immediately; a fresh key_load is required.
- SubWord uses the team's standard forward S-box on 4 bytes, combinationally.
- Single register stage per word; no multicycle paths.

Test Plan:
- Reset, then key_load with Nk=4 and key 2b7e151628aed2a6abf7158809cf4f3c:
  - w[4] = a0fafe17 one cycle after load.
  - key_ready rises exactly 40 cycles after the load edge.
  - keys_out[127:0] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=8, Nr=14, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - w[8] = 9ba35411.
  - key_ready rises 52 cycles after load.
  - keys_out[127:0] = fe4890d1e6188d0b046df344706c631e.
- Restart mid-expansion: key_load at cycle 20 with key 000102030405060708090a0b0c0d0e0f:
  - key_ready stays 0 until 40 cycles after the second load.
  - Final result matches the single-load golden result for that key.
- Reset pulse mid-EXPAND:
  - keys_out = 0, key_ready = 0, busy = 0 asynchronously.
  - No progress until the next key_load.
- Integration with the encrypt pipeline: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff.
  - Once the encrypt stage signals done, out = 69c4e0d86a7b0430d8cdb78070b4c55a.
- key_ready hold:
  - key_in toggles randomly for 100 cycles after key_ready with key_load=0.
  - keys_out and key_ready stay unchanged.

Source files
------------

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one 32-bit schedule word per clock through a single shared
// SubWord unit. Presents the packed round-key bus and a level key_ready flag.
module aes_key_expand_seq #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [Nk*32-1:0]       key_in,
  input  logic                   key_load,
  output logic [(Nr+1)*128-1:0]  keys_out,
  output logic                   key_ready,
  output logic                   busy
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW + 1);

  // Forward S-box, entry 0 at the MSBs.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    int msb;
    msb = 2047 - 8 * int'(x);
    return SBOX[msb -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        state;
  logic [31:0]   w [NW];
  logic [31:0]   key_words [Nk];
  logic [IW-1:0] idx;
  logic [2:0]    mod_cnt;
  logic [7:0]    rcon;

  logic [31:0]   prev_word, back_word, sub_in, sub_out, temp, new_word;

  for (genvar g = 0; g < Nk; g++) begin : g_key
    assign key_words[g] = key_in[(Nk-g)*32-1 -: 32];
  end

  for (genvar g = 0; g < NW; g++) begin : g_out
    assign keys_out[(NW-g)*32-1 -: 32] = w[g];
  end

  always_comb begin
    prev_word = w[idx - IW'(1)];
    back_word = w[idx - IW'(Nk)];
    sub_in    = (mod_cnt == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = sub_word(sub_in);
    if (mod_cnt == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (Nk == 8 && mod_cnt == 3'd4)
      temp = sub_out;
    else
      temp = prev_word;
    new_word  = back_word ^ temp;
  end

  // NOTE: the schedule store is reset word-by-word because keys_out must read zero after
  // reset; this is a deliberate register array, not an inferable RAM.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, matching the one-word-per-edge schedule recurrence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      for (int j = 0; j < NW; j++) w[j] <= 32'h0;
      idx       <= '0;
      mod_cnt   <= 3'd0;
      rcon      <= 8'h01;
      key_ready <= 1'b0;
      busy      <= 1'b0;
    end else if (key_load) begin
      // A load restarts from any state; stale words are cleared so nothing partial survives.
      for (int j = 0; j < Nk; j++) w[j] <= key_words[j];
      for (int j = Nk; j < NW; j++) w[j] <= 32'h0;
      state     <= EXPAND;
      idx       <= IW'(Nk);
      mod_cnt   <= 3'd0;
      rcon      <= 8'h01;
      key_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        EXPAND: begin
          w[idx]  <= new_word;
          idx     <= idx + IW'(1);
          mod_cnt <= (mod_cnt == 3'(Nk - 1)) ? 3'd0 : mod_cnt + 3'd1;
          if (mod_cnt == 3'd0) rcon <= xtime(rcon);
          if (idx == IW'(NW - 1)) begin
            state     <= DONE;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule
